epc_filter_match: RTL and testbench
===================================

EPC_FILTER_MATCH -- requirements
Module: epc_filter_match

Interface
REQ-001 SHALL have parameter ID_BITS, default 96, meaning the expected tag ID length in bits.
REQ-002 SHALL have parameter WIN, default 32, meaning the compare window width in bits.
REQ-003 SHALL have parameter NUM_FILT, default 4, meaning the number of filter entries.
REQ-004 SHALL have port Clk, input, 1 bit: clock, all logic on the rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port SyncReset, input, 1 bit: synchronous clear to the reset state.
REQ-007 SHALL have port FrameStart, input, 1 bit: one-cycle pulse marking the start of a decoded tag ID.
REQ-008 SHALL have ports BitValid (input, 1 bit) and BitData (input, 1 bit): one ID bit per BitValid cycle, MSB first.
REQ-009 SHALL have port FrameEnd, input, 1 bit: one-cycle pulse marking the end of the ID.
REQ-010 SHALL have port Offset, input, 7 bits: ID bit index of the first window bit.
REQ-011 SHALL have ports FiltValue and FiltMask, inputs, NUM_FILT*WIN bits each, with entry k at bits [k*WIN+WIN-1 : k*WIN]; both are driven by the filter register bank.
REQ-012 SHALL have port FiltEnable, input, NUM_FILT bits: per-entry enable.
REQ-013 SHALL have port Busy, output, 1 bit: high while a frame is being received.
REQ-014 SHALL have ports MatchValid (output, 1 bit), MatchHit (output, 1 bit), MatchVec (output, NUM_FILT bits) and MatchIndex (output, 2 bits): the result of one frame.
REQ-015 SHALL have port LenError, output, 1 bit: qualified by MatchValid; signals a bad frame length or an illegal Offset.

Function
REQ-016 SHALL implement FSM states IDLE, RECV and REPORT.
REQ-017 SHALL move to RECV on FrameStart in any state, clear the bit counter and window, and latch Offset.
REQ-018 SHALL treat BitValid in the FrameStart cycle as bit 0 of the new frame.
REQ-019 SHALL, in RECV, increment a 7-bit counter per BitValid and shift BitData into the window LSB when Offset <= index <= Offset+WIN-1, so that window bit WIN-1 holds ID bit Offset.
REQ-020 SHALL ignore BitValid and FrameEnd in IDLE and REPORT.
REQ-021 SHALL, on FrameEnd in RECV, include any same-cycle BitValid bit and then go to REPORT.
REQ-022 SHALL stay in REPORT for exactly one cycle and then return to IDLE, unless FrameStart is present in that cycle.
REQ-023 SHALL drive MatchValid high only in the REPORT cycle, i.e. exactly 1 cycle after FrameEnd.
REQ-024 SHALL register MatchHit, MatchVec, MatchIndex and LenError at REPORT entry and hold them until the next REPORT.
REQ-025 SHALL compute entry k as matching when FiltEnable[k] is set and ((window XOR FiltValue_k) AND FiltMask_k) equals zero.
- An all-zero mask therefore matches any ID on an enabled entry.
REQ-026 SHALL sample the filter inputs in the FrameEnd cycle.
REQ-027 SHALL set MatchHit to the OR of MatchVec.
REQ-028 SHALL set MatchIndex to the lowest set index of MatchVec, or 0 when MatchVec is zero.
REQ-029 SHALL set LenError when the received bit count is not ID_BITS, when a BitValid arrives after bit ID_BITS-1 (the counter saturates), or when the latched Offset exceeds ID_BITS-WIN.
REQ-030 SHALL force MatchVec to zero and MatchHit to 0 whenever LenError is set.
REQ-031 SHALL, on FrameStart while in RECV, abort the current frame with no report and restart.
REQ-032 SHALL drive Busy high exactly when the state is RECV.

Reset
REQ-033 SHALL, on Reset or SyncReset, set the state to IDLE, clear the counter and window, and drive Busy=0, MatchValid=0, MatchHit=0, MatchVec=0, MatchIndex=0 and LenError=0.
REQ-034 SHALL, on reset asserted mid-frame, discard the frame and produce no MatchValid.
REQ-035 SHALL give SyncReset priority over FrameStart in the same cycle.

Structure
REQ-036 SHALL place the FSM state encodings and the default ID_BITS, WIN and NUM_FILT values in the shared RFID constants package.
REQ-037 SHALL implement the per-entry masked compare as sub-module filter_entry_compare, instantiated NUM_FILT times.
REQ-038 SHALL register all outputs, with no combinational path from the inputs to the outputs.

Verification
REQ-039 SHALL cover a good match:
- Stimulus: Offset=0; entry 0 value 0x3000_1234, mask 0xFFFF_FFFF, enabled; 96-bit ID starting 0x30001234; FrameEnd.
- Response: MatchValid 1 cycle later, MatchHit=1, MatchVec=0001, MatchIndex=0, LenError=0.
REQ-040 SHALL cover multiple hits:
- Stimulus: entries 1 and 3 enabled with mask 0 and the same ID.
- Response: MatchVec=1010, MatchIndex=1.
REQ-041 SHALL cover a short frame:
- Stimulus: 95 bits, then FrameEnd.
- Response: LenError=1, MatchHit=0, MatchVec=0.
REQ-042 SHALL cover an illegal Offset:
- Stimulus: Offset=65 with a 96-bit frame.
- Response: LenError=1.
- Stimulus: Offset=64, entry 2 value equal to the last 32 ID bits.
- Response: MatchVec=0100.
REQ-043 SHALL cover a restart and a reset:
- Stimulus: FrameStart at bit 40 of a frame.
- Response: no MatchValid for the aborted frame; the following full frame reports normally.
- Stimulus: Reset pulsed at bit 50.
- Response: all outputs 0, state IDLE, no MatchValid.
REQ-044 SHALL cover back-to-back frames:
- Stimulus: FrameStart in the REPORT cycle.
- Response: MatchValid lasts one cycle and Busy=1 the next cycle.

Source files
------------

// File: rtl/epc_filter_match_pkg.sv
// Shared RFID constants: default EPC filter geometry and the frame FSM encoding.
package epc_filter_match_pkg;

    localparam int DEF_ID_BITS  = 96;
    localparam int DEF_WIN      = 32;
    localparam int DEF_NUM_FILT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

endpackage

// File: rtl/filter_entry_compare.sv
// One filter entry: masked equality of the captured ID window against a stored value.
module filter_entry_compare
    import epc_filter_match_pkg::*;
#(
    parameter int WIN = DEF_WIN
) (
    input  logic           enable,
    input  logic [WIN-1:0] window,
    input  logic [WIN-1:0] value,
    input  logic [WIN-1:0] mask,
    output logic           match
);

    assign match = enable && (((window ^ value) & mask) == '0);

endmodule

// File: rtl/epc_filter_match.sv
// Collects a serial EPC tag ID, captures a WIN-bit window at a programmable offset
// and reports which filter entries match once the frame ends.
module epc_filter_match
    import epc_filter_match_pkg::*;
#(
    parameter int ID_BITS  = DEF_ID_BITS,
    parameter int WIN      = DEF_WIN,
    parameter int NUM_FILT = DEF_NUM_FILT
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    SyncReset,
    input  logic                    FrameStart,
    input  logic                    BitValid,
    input  logic                    BitData,
    input  logic                    FrameEnd,
    input  logic [6:0]              Offset,
    input  logic [NUM_FILT*WIN-1:0] FiltValue,
    input  logic [NUM_FILT*WIN-1:0] FiltMask,
    input  logic [NUM_FILT-1:0]     FiltEnable,
    output logic                    Busy,
    output logic                    MatchValid,
    output logic                    MatchHit,
    output logic [NUM_FILT-1:0]     MatchVec,
    output logic [1:0]              MatchIndex,
    output logic                    LenError
);

    localparam logic [6:0] FULL_COUNT = 7'(ID_BITS);
    localparam logic [6:0] MAX_OFFSET = 7'(ID_BITS - WIN);
    localparam logic [7:0] WIN_SPAN   = 8'(WIN - 1);

    state_e              state_q, state_d;
    logic [6:0]          cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [6:0]          offset_q, offset_d;
    logic [WIN-1:0]      window_q, window_d;
    logic                busy_q, busy_d;
    logic                match_valid_q, match_valid_d;
    logic                match_hit_q, match_hit_d;
    logic [NUM_FILT-1:0] match_vec_q, match_vec_d;
    logic [1:0]          match_index_q, match_index_d;
    logic                len_error_q, len_error_d;

    logic [6:0]          base_cnt, upd_cnt, base_offset;
    logic                base_ovf, upd_ovf;
    logic [WIN-1:0]      base_window, upd_window;
    logic                take_bit, in_window, frame_len_error;
    logic [NUM_FILT-1:0] hit_vec, result_vec;
    logic [1:0]          result_index;

    // A FrameStart restarts bookkeeping from zero, and its own BitValid is already bit 0.
    always_comb begin
        base_cnt    = FrameStart ? 7'd0 : cnt_q;
        base_ovf    = FrameStart ? 1'b0 : ovf_q;
        base_offset = FrameStart ? Offset : offset_q;
        base_window = FrameStart ? '0 : window_q;
        take_bit    = BitValid && (FrameStart || (state_q == ST_RECV));
        in_window   = (base_cnt >= base_offset) &&
                      ({1'b0, base_cnt} <= ({1'b0, base_offset} + WIN_SPAN));
        upd_cnt     = base_cnt;
        upd_ovf     = base_ovf;
        upd_window  = base_window;
        if (take_bit) begin
            if (base_cnt >= FULL_COUNT) begin
                upd_ovf = 1'b1;
            end else begin
                upd_cnt = base_cnt + 7'd1;
                if (in_window) begin
                    upd_window = {base_window[WIN-2:0], BitData};
                end
            end
        end
        frame_len_error = (upd_cnt != FULL_COUNT) || upd_ovf || (base_offset > MAX_OFFSET);
    end

    for (genvar k = 0; k < NUM_FILT; k++) begin : g_entry
        filter_entry_compare #(
            .WIN(WIN)
        ) u_compare (
            .enable(FiltEnable[k]),
            .window(upd_window),
            .value (FiltValue[k*WIN +: WIN]),
            .mask  (FiltMask[k*WIN +: WIN]),
            .match (hit_vec[k])
        );
    end

    always_comb begin
        result_vec   = frame_len_error ? '0 : hit_vec;
        result_index = 2'd0;
        for (int k = NUM_FILT - 1; k >= 0; k--) begin
            if (result_vec[k]) begin
                result_index = 2'(k);
            end
        end
    end

    // SyncReset outranks FrameStart; FrameStart outranks everything else in any state.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ovf_d         = ovf_q;
        offset_d      = offset_q;
        window_d      = window_q;
        match_valid_d = 1'b0;
        match_hit_d   = match_hit_q;
        match_vec_d   = match_vec_q;
        match_index_d = match_index_q;
        len_error_d   = len_error_q;
        if (SyncReset) begin
            state_d     = ST_IDLE;
            cnt_d       = 7'd0;
            ovf_d       = 1'b0;
            offset_d    = 7'd0;
            window_d    = '0;
            match_hit_d = 1'b0;
            match_vec_d = '0;
            match_index_d = 2'd0;
            len_error_d = 1'b0;
        end else if (FrameStart) begin
            state_d  = ST_RECV;
            cnt_d    = upd_cnt;
            ovf_d    = upd_ovf;
            offset_d = base_offset;
            window_d = upd_window;
        end else begin
            case (state_q)
                ST_RECV: begin
                    cnt_d    = upd_cnt;
                    ovf_d    = upd_ovf;
                    window_d = upd_window;
                    if (FrameEnd) begin
                        state_d       = ST_REPORT;
                        match_valid_d = 1'b1;
                        match_hit_d   = |result_vec;
                        match_vec_d   = result_vec;
                        match_index_d = result_index;
                        len_error_d   = frame_len_error;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d == ST_RECV);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 7'd0;
            ovf_q         <= 1'b0;
            offset_q      <= 7'd0;
            window_q      <= '0;
            busy_q        <= 1'b0;
            match_valid_q <= 1'b0;
            match_hit_q   <= 1'b0;
            match_vec_q   <= '0;
            match_index_q <= 2'd0;
            len_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
            offset_q      <= offset_d;
            window_q      <= window_d;
            busy_q        <= busy_d;
            match_valid_q <= match_valid_d;
            match_hit_q   <= match_hit_d;
            match_vec_q   <= match_vec_d;
            match_index_q <= match_index_d;
            len_error_q   <= len_error_d;
        end
    end

    assign Busy       = busy_q;
    assign MatchValid = match_valid_q;
    assign MatchHit   = match_hit_q;
    assign MatchVec   = match_vec_q;
    assign MatchIndex = match_index_q;
    assign LenError   = len_error_q;

endmodule

// File: tb/tb_epc_filter_match.sv
// Directed and randomized frames for epc_filter_match, checked against a
// whole-frame reference model (ID vector, offset arithmetic, filter table).
module tb_epc_filter_match;

    localparam int ID_BITS  = 96;
    localparam int WIN      = 32;
    localparam int NUM_FILT = 4;

    logic                    Clk = 1'b0;
    logic                    Reset;
    logic                    SyncReset;
    logic                    FrameStart;
    logic                    BitValid;
    logic                    BitData;
    logic                    FrameEnd;
    logic [6:0]              Offset;
    logic [NUM_FILT*WIN-1:0] FiltValue;
    logic [NUM_FILT*WIN-1:0] FiltMask;
    logic [NUM_FILT-1:0]     FiltEnable;
    logic                    Busy;
    logic                    MatchValid;
    logic                    MatchHit;
    logic [NUM_FILT-1:0]     MatchVec;
    logic [1:0]              MatchIndex;
    logic                    LenError;

    int compared   = 0;
    int mismatched = 0;
    int mv_count   = 0;

    logic [WIN-1:0]      filt_val  [NUM_FILT];
    logic [WIN-1:0]      filt_mask [NUM_FILT];
    logic [NUM_FILT-1:0] filt_en;
    logic [NUM_FILT-1:0] exp_vec;
    logic [1:0]          exp_idx;
    logic                exp_err;

    epc_filter_match #(
        .ID_BITS (ID_BITS),
        .WIN     (WIN),
        .NUM_FILT(NUM_FILT)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .SyncReset (SyncReset),
        .FrameStart(FrameStart),
        .BitValid  (BitValid),
        .BitData   (BitData),
        .FrameEnd  (FrameEnd),
        .Offset    (Offset),
        .FiltValue (FiltValue),
        .FiltMask  (FiltMask),
        .FiltEnable(FiltEnable),
        .Busy      (Busy),
        .MatchValid(MatchValid),
        .MatchHit  (MatchHit),
        .MatchVec  (MatchVec),
        .MatchIndex(MatchIndex),
        .LenError  (LenError)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (MatchValid === 1'b1) mv_count++;
    end

    initial begin
        #10000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Filter inputs carry junk except in the FrameEnd cycle, where the real table is sampled.
    task automatic drive_filters(input bit intended);
        for (int k = 0; k < NUM_FILT; k++) begin
            FiltValue[k*WIN +: WIN] = intended ? filt_val[k]  : WIN'($urandom);
            FiltMask[k*WIN +: WIN]  = intended ? filt_mask[k] : WIN'($urandom);
        end
        FiltEnable = intended ? filt_en : NUM_FILT'($urandom);
    endtask

    task automatic idle_inputs();
        FrameStart = 1'b0;
        BitValid   = 1'b0;
        BitData    = 1'b0;
        FrameEnd   = 1'b0;
        drive_filters(1'b0);
    endtask

    function automatic logic id_bit(input logic [ID_BITS-1:0] id, input int i);
        if (i < ID_BITS) return id[ID_BITS-1-i];
        return 1'($urandom);
    endfunction

    function automatic logic [WIN-1:0] window_of(input logic [ID_BITS-1:0] id, input int off);
        logic [ID_BITS-1:0] shifted;
        if (off > ID_BITS - WIN) return '0;
        shifted = id >> (ID_BITS - WIN - off);
        return shifted[WIN-1:0];
    endfunction

    task automatic drive_frame(input logic [ID_BITS-1:0] id, input int nbits, input logic [6:0] off,
                               input int stop_at, input bit chk_b2b);
        bit end_with_bit;
        bit lead_idle;
        bit first;
        int i;
        end_with_bit = ($urandom_range(0, 1) == 1);
        lead_idle    = ($urandom_range(0, 3) == 0);
        first        = 1'b1;
        i            = 0;
        while (i < nbits) begin
            if (i == stop_at) begin
                idle_inputs();
                return;
            end
            FrameStart = first;
            Offset     = first ? off : 7'($urandom);
            FrameEnd   = 1'b0;
            if ((first && lead_idle) || (!first && $urandom_range(0, 4) == 0)) begin
                BitValid = 1'b0;
                BitData  = 1'($urandom);
            end else begin
                BitValid = 1'b1;
                BitData  = id_bit(id, i);
                FrameEnd = end_with_bit && (i == nbits - 1);
                i++;
            end
            drive_filters(FrameEnd);
            tick();
            if (first && chk_b2b) begin
                check_output("b2b_valid_one_cycle", 32'(MatchValid), 32'd0);
                check_output("b2b_busy", 32'(Busy), 32'd1);
            end
            first = 1'b0;
        end
        if (!end_with_bit) begin
            FrameStart = 1'b0;
            BitValid   = 1'b0;
            FrameEnd   = 1'b1;
            drive_filters(1'b1);
            tick();
        end
        idle_inputs();
    endtask

    task automatic check_report(input string tag, input logic [ID_BITS-1:0] id, input int nbits, input int off);
        logic [WIN-1:0] win;
        win     = window_of(id, off);
        exp_err = (nbits != ID_BITS) || (off > ID_BITS - WIN);
        exp_vec = '0;
        for (int k = 0; k < NUM_FILT; k++) begin
            if (!exp_err && filt_en[k] && (((win ^ filt_val[k]) & filt_mask[k]) == '0)) exp_vec[k] = 1'b1;
        end
        exp_idx = 2'd0;
        for (int k = 0; k < NUM_FILT; k++) begin
            if (exp_vec[k]) begin
                exp_idx = 2'(k);
                break;
            end
        end
        check_output({tag, "_valid"}, 32'(MatchValid), 32'd1);
        check_output({tag, "_busy"},  32'(Busy),       32'd0);
        check_output({tag, "_hit"},   32'(MatchHit),   32'(exp_vec != '0));
        check_output({tag, "_vec"},   32'(MatchVec),   32'(exp_vec));
        check_output({tag, "_idx"},   32'(MatchIndex), 32'(exp_idx));
        check_output({tag, "_err"},   32'(LenError),   32'(exp_err));
    endtask

    task automatic check_hold(input string tag);
        tick();
        check_output({tag, "_valid"}, 32'(MatchValid), 32'd0);
        check_output({tag, "_busy"},  32'(Busy),       32'd0);
        check_output({tag, "_vec"},   32'(MatchVec),   32'(exp_vec));
        check_output({tag, "_err"},   32'(LenError),   32'(exp_err));
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_busy"},  32'(Busy),       32'd0);
        check_output({tag, "_valid"}, 32'(MatchValid), 32'd0);
        check_output({tag, "_hit"},   32'(MatchHit),   32'd0);
        check_output({tag, "_vec"},   32'(MatchVec),   32'd0);
        check_output({tag, "_idx"},   32'(MatchIndex), 32'd0);
        check_output({tag, "_err"},   32'(LenError),   32'd0);
    endtask

    task automatic set_random_filters(input logic [ID_BITS-1:0] id, input int off);
        logic [WIN-1:0] win;
        win = (off <= ID_BITS - WIN) ? window_of(id, off) : WIN'($urandom);
        for (int k = 0; k < NUM_FILT; k++) begin
            case ($urandom_range(0, 3))
                0:       filt_mask[k] = '0;
                1:       filt_mask[k] = '1;
                default: filt_mask[k] = WIN'($urandom);
            endcase
            filt_val[k] = ($urandom_range(0, 1) == 1) ? (win ^ (WIN'($urandom) & ~filt_mask[k])) : WIN'($urandom);
        end
        filt_en = NUM_FILT'($urandom);
    endtask

    task automatic clear_filters();
        for (int k = 0; k < NUM_FILT; k++) begin
            filt_val[k]  = '0;
            filt_mask[k] = '1;
        end
        filt_en = '0;
    endtask

    initial begin
        logic [ID_BITS-1:0] id_a;
        logic [ID_BITS-1:0] id_b;
        int mv_before;
        int off_a;
        int off_b;

        Reset     = 1'b1;
        SyncReset = 1'b0;
        Offset    = 7'd0;
        idle_inputs();
        clear_filters();
        tick();
        tick();
        check_all_zero("reset");
        Reset = 1'b0;
        tick();

        $display("[TB] good match at offset 0");
        id_a = {32'h3000_1234, $urandom, $urandom};
        clear_filters();
        filt_val[0]  = 32'h3000_1234;
        filt_mask[0] = 32'hFFFF_FFFF;
        filt_en      = 4'b0001;
        drive_frame(id_a, ID_BITS, 7'd0, -1, 1'b0);
        check_report("good", id_a, ID_BITS, 0);
        check_output("good_vec_const", 32'(MatchVec), 32'h1);
        check_hold("good_hold");

        $display("[TB] multiple hits with zero masks");
        filt_mask[1] = '0;
        filt_mask[3] = '0;
        filt_val[1]  = $urandom;
        filt_val[3]  = $urandom;
        filt_en      = 4'b1010;
        drive_frame(id_a, ID_BITS, 7'd0, -1, 1'b0);
        check_report("multi", id_a, ID_BITS, 0);
        check_output("multi_vec_const", 32'(MatchVec), 32'hA);
        check_output("multi_idx_const", 32'(MatchIndex), 32'd1);
        check_hold("multi_hold");

        $display("[TB] short frame");
        drive_frame(id_a, ID_BITS - 1, 7'd0, -1, 1'b0);
        check_report("short", id_a, ID_BITS - 1, 0);
        check_output("short_err_const", 32'(LenError), 32'd1);
        check_hold("short_hold");

        $display("[TB] offset 65 and offset 64");
        drive_frame(id_a, ID_BITS, 7'd65, -1, 1'b0);
        check_report("off65", id_a, ID_BITS, 65);
        check_output("off65_err_const", 32'(LenError), 32'd1);
        check_hold("off65_hold");
        clear_filters();
        filt_val[2] = id_a[WIN-1:0];
        filt_val[0] = ~id_a[WIN-1:0];
        filt_en     = 4'b0101;
        drive_frame(id_a, ID_BITS, 7'd64, -1, 1'b0);
        check_report("off64", id_a, ID_BITS, 64);
        check_output("off64_vec_const", 32'(MatchVec), 32'h4);
        check_hold("off64_hold");

        $display("[TB] restart at bit 40");
        mv_before = mv_count;
        id_a  = {$urandom, $urandom, $urandom};
        id_b  = {$urandom, $urandom, $urandom};
        off_b = $urandom_range(0, ID_BITS - WIN);
        set_random_filters(id_b, off_b);
        drive_frame(id_a, ID_BITS, 7'd0, 40, 1'b0);
        check_output("abort_busy", 32'(Busy), 32'd1);
        drive_frame(id_b, ID_BITS, 7'(off_b), -1, 1'b0);
        check_report("restart", id_b, ID_BITS, off_b);
        check_hold("restart_hold");
        check_output("restart_mv_count", 32'(mv_count - mv_before), 32'd1);

        $display("[TB] reset at bit 50");
        mv_before = mv_count;
        drive_frame(id_a, ID_BITS, 7'd0, 50, 1'b0);
        Reset = 1'b1;
        #2;
        check_all_zero("midreset");
        tick();
        Reset    = 1'b0;
        BitValid = 1'b1;
        FrameEnd = 1'b1;
        tick();
        idle_inputs();
        tick();
        tick();
        check_output("midreset_busy_after", 32'(Busy), 32'd0);
        check_output("midreset_mv_count", 32'(mv_count - mv_before), 32'd0);

        $display("[TB] back-to-back frames");
        mv_before = mv_count;
        off_a = $urandom_range(0, ID_BITS - WIN);
        off_b = $urandom_range(0, ID_BITS - WIN);
        set_random_filters(id_a, off_a);
        drive_frame(id_a, ID_BITS, 7'(off_a), -1, 1'b0);
        check_report("b2b_first", id_a, ID_BITS, off_a);
        set_random_filters(id_b, off_b);
        drive_frame(id_b, ID_BITS, 7'(off_b), -1, 1'b1);
        check_report("b2b_second", id_b, ID_BITS, off_b);
        check_hold("b2b_hold");
        check_output("b2b_mv_count", 32'(mv_count - mv_before), 32'd2);

        $display("[TB] SyncReset beats FrameStart");
        drive_frame(id_a, ID_BITS, 7'd0, 30, 1'b0);
        SyncReset  = 1'b1;
        FrameStart = 1'b1;
        BitValid   = 1'b1;
        tick();
        check_all_zero("syncreset");
        SyncReset = 1'b0;
        idle_inputs();
        tick();
        check_output("syncreset_idle", 32'(Busy), 32'd0);

        $display("[TB] randomized frames");
        for (int n = 0; n < 24; n++) begin : rand_frames
            logic [ID_BITS-1:0] id_r;
            int nbits_r;
            int off_r;
            id_r    = {$urandom, $urandom, $urandom};
            nbits_r = ($urandom_range(0, 4) == 0) ? int'($urandom_range(90, 140)) : ID_BITS;
            off_r   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(65, 127))
                                                  : int'($urandom_range(0, ID_BITS - WIN));
            set_random_filters(id_r, off_r);
            drive_frame(id_r, nbits_r, 7'(off_r), -1, 1'b0);
            check_report("rand", id_r, nbits_r, off_r);
            if ($urandom_range(0, 1) == 1) check_hold("rand_hold");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
